// File: rtl/garota_reset_ctrl.sv
// Reset sequencer for GAROTA violations: turns UART/IRQ violation requests into a
// stretched CPU reset and keeps sticky cause/count registers on the peripheral bus.
module garota_reset_ctrl #(
  parameter int unsigned RST_HOLD  = 16,
  parameter logic [13:0] BASE_ADDR = 14'h00C8,
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_viol,
  input  logic        irq_viol,
  input  logic [15:0] pc,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic        cpu_rst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [7:0]  HOLD_LAST  = 8'(RST_HOLD - 1);
  localparam logic [16:0] SMEM_FIRST = {1'b0, SMEM_BASE};
  localparam logic [16:0] SMEM_LAST  = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd1;
  localparam logic [13:0] CAUSE_ADDR = BASE_ADDR;
  localparam logic [13:0] COUNT_ADDR = BASE_ADDR + 14'd1;

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [2:0]  cause_q, cause_d;
  logic [7:0]  count_q, count_d;

  logic        viol_any;
  logic        event_start;
  logic        in_tcb;
  logic        wr_ok;
  logic        rd_ok;
  logic        cause_sel;
  logic        count_sel;
  logic [2:0]  cause_clr;
  logic [7:0]  count_base;
  logic        unused_din;

  assign viol_any    = uart_viol | irq_viol;
  assign event_start = (state_q == S_IDLE) && viol_any;

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= 8'd0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Sequencer: next state
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (viol_any) begin
          state_d    = S_HOLD;
          hold_cnt_d = 8'd0;
        end
      end
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = viol_any ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (!viol_any) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer: output (registered so cpu_rst is glitch-free)
  always_comb begin
    cpu_rst_d = (state_d != S_IDLE);
  end

  assign cpu_rst = cpu_rst_q;

  // ---------------------------------------------------------------------------
  // Peripheral bus decode
  // ---------------------------------------------------------------------------
  assign in_tcb    = ({1'b0, pc} >= SMEM_FIRST) && ({1'b0, pc} <= SMEM_LAST);
  assign wr_ok     = per_en && (per_we != 2'b00) && in_tcb;
  assign rd_ok     = per_en && (per_we == 2'b00);
  assign cause_sel = (per_addr == CAUSE_ADDR);
  assign count_sel = (per_addr == COUNT_ADDR);
  assign unused_din = ^per_din[15:3];

  // Violation sets win over a same-cycle clear; a same-cycle COUNT clear and
  // new event leave the count at one.
  always_comb begin
    cause_clr  = (wr_ok && cause_sel) ? per_din[2:0] : 3'b000;
    cause_d    = (cause_q & ~cause_clr) | {1'b0, irq_viol, uart_viol};
    count_base = (wr_ok && count_sel) ? 8'd0 : count_q;
    count_d    = count_base;
    if (event_start && (count_base != 8'hFF)) begin
      count_d = count_base + 8'd1;
    end
  end

  // NOTE: the sticky registers reset only on reset_n, never on cpu_rst, so the
  // recorded cause survives the CPU reset it triggers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= 3'b100;
      count_q <= 8'd0;
    end else begin
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (rd_ok && cause_sel) begin
      per_dout = {13'd0, cause_q};
    end else if (rd_ok && count_sel) begin
      per_dout = {8'd0, count_q};
    end
  end

endmodule

// File: tb/tb_garota_reset_ctrl.sv
// Directed self-checking bench for garota_reset_ctrl with hand-computed expectations.
module tb_garota_reset_ctrl;

  localparam logic [13:0] CAUSE_A = 14'h00C8;
  localparam logic [13:0] COUNT_A = 14'h00C9;

  logic        clk;
  logic        reset_n;
  logic        uart_viol;
  logic        irq_viol;
  logic [15:0] pc;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        cpu_rst;

  int n_checks = 0;
  int n_pass   = 0;

  garota_reset_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_viol(uart_viol),
    .irq_viol (irq_viol),
    .pc       (pc),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_dout (per_dout),
    .cpu_rst  (cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Combinational read, performed just after a falling edge.
  task automatic rd(input logic [13:0] a, output logic [15:0] d);
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = a;
    #1;
    d        = per_dout;
    per_en   = 1'b0;
    per_addr = 14'd0;
  endtask

  // One-cycle write, sampled on the next rising edge.
  task automatic wr(input logic [13:0] a, input logic [15:0] din, input logic [15:0] pcv);
    per_en   = 1'b1;
    per_we   = 2'b11;
    per_addr = a;
    per_din  = din;
    pc       = pcv;
    @(negedge clk);
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_addr = 14'd0;
    per_din  = 16'd0;
    pc       = 16'h0000;
  endtask

  // Counts falling edges with cpu_rst high, starting with the current one.
  task automatic measure(output int w);
    w = 0;
    while (cpu_rst === 1'b1 && w < 1000) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic u, input logic i, output int w);
    uart_viol = u;
    irq_viol  = i;
    @(negedge clk);
    uart_viol = 1'b0;
    irq_viol  = 1'b0;
    measure(w);
  endtask

  logic [15:0] d;
  int          w, w2, bad;

  initial begin
    reset_n   = 1'b0;
    uart_viol = 1'b0;
    irq_viol  = 1'b0;
    pc        = 16'h0000;
    per_en    = 1'b0;
    per_we    = 2'b00;
    per_addr  = 14'd0;
    per_din   = 16'd0;
    repeat (3) @(negedge clk);

    // Power-on reset
    check("por_rst_in_reset", {15'd0, cpu_rst}, 16'd1);
    rd(CAUSE_A, d); check("por_cause_in_reset", d, 16'h0004);
    rd(COUNT_A, d); check("por_count_in_reset", d, 16'h0000);
    reset_n = 1'b1;
    measure(w);
    check("por_width", 16'(w), 16'd16);
    rd(CAUSE_A, d); check("por_cause", d, 16'h0004);
    rd(COUNT_A, d); check("por_count", d, 16'h0000);
    check("idle_rst_low", {15'd0, cpu_rst}, 16'd0);
    check("dout_unselected", per_dout, 16'h0000);
    rd(14'h00CA, d); check("dout_other_addr", d, 16'h0000);

    // Single one-cycle UART request
    pulse(1'b1, 1'b0, w);
    check("uart_width", 16'(w), 16'd16);
    rd(CAUSE_A, d); check("uart_cause", d, 16'h0005);
    rd(COUNT_A, d); check("uart_count", d, 16'h0001);

    // Long IRQ request: HOLD then WAIT, one event
    irq_viol = 1'b1;
    w = 0;
    repeat (39) begin
      @(negedge clk);
      if (cpu_rst) w++;
    end
    @(negedge clk);
    irq_viol = 1'b0;
    measure(w2);
    check("irq_long_width", 16'(w + w2), 16'd40);
    rd(CAUSE_A, d); check("irq_cause", d, 16'h0007);
    rd(COUNT_A, d); check("irq_count", d, 16'h0002);

    // Clear protection on CAUSE
    wr(CAUSE_A, 16'h0007, 16'h4000);
    rd(CAUSE_A, d); check("cause_clr_outside", d, 16'h0007);
    wr(CAUSE_A, 16'h0007, 16'hA100);
    rd(CAUSE_A, d); check("cause_clr_tcb", d, 16'h0000);

    // Both requests in the same cycle
    pulse(1'b1, 1'b1, w);
    check("both_width", 16'(w), 16'd16);
    rd(CAUSE_A, d); check("both_cause", d, 16'h0003);
    rd(COUNT_A, d); check("both_count", d, 16'h0003);

    // TCB window edges and per-bit clear
    wr(COUNT_A, 16'h0000, 16'hE000);
    rd(COUNT_A, d); check("count_clr_above_tcb", d, 16'h0003);
    wr(CAUSE_A, 16'h0001, 16'h9FFF);
    rd(CAUSE_A, d); check("cause_clr_below_tcb", d, 16'h0003);
    wr(CAUSE_A, 16'h0002, 16'hA000);
    rd(CAUSE_A, d); check("cause_clr_bit1_base", d, 16'h0001);
    wr(COUNT_A, 16'h0000, 16'hDFFF);
    rd(COUNT_A, d); check("count_clr_tcb_top", d, 16'h0000);

    // Saturation: back-to-back events with no cooldown
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      pulse(1'b1, 1'b0, w);
      if (w != 16) bad++;
    end
    check("sat_widths_bad", 16'(bad), 16'd0);
    rd(COUNT_A, d); check("count_saturated", d, 16'h00FF);

    // COUNT clear racing a new event
    uart_viol = 1'b1;
    wr(COUNT_A, 16'h0000, 16'hA100);
    uart_viol = 1'b0;
    measure(w);
    check("race_count_width", 16'(w), 16'd16);
    rd(COUNT_A, d); check("race_count", d, 16'h0001);

    // CAUSE clear racing a UART event: bit0 held, others cleared
    pulse(1'b0, 1'b1, w);
    rd(CAUSE_A, d); check("pre_race_cause", d, 16'h0003);
    uart_viol = 1'b1;
    wr(CAUSE_A, 16'h0007, 16'hA100);
    uart_viol = 1'b0;
    measure(w);
    rd(CAUSE_A, d); check("race_cause", d, 16'h0001);
    rd(COUNT_A, d); check("final_count", d, 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
